// File: rtl/key_counter_pkg.sv
// rtl/key_counter_pkg.sv - shared constants and types for the key counter sequencer
//
// Purpose: key index assignments and the step auto-repeat state encoding,
//          used by key_counter_sequencer.
// Ports:   none (package)

package key_counter_pkg;

    // Key roles within the 4-bit key_n / pressed vectors
    localparam int NUM_KEYS = 4;
    localparam int KEY_STEP = 0;
    localparam int KEY_DIR  = 1;
    localparam int KEY_CLR  = 2;
    localparam int KEY_MODE = 3;

    // Step key auto-repeat states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, debouncer and press-edge detector
//
// Purpose: brings one raw active-low button into the clk domain, accepts a
//          new level only after DEBOUNCE_CYCLES consecutive stable samples,
//          and strobes press_evt for one cycle when the accepted level falls.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   key_n      in   raw asynchronous button, active-low
//   pressed    out  debounced key state, 1 = held
//   press_evt  out  one-cycle strobe on an accepted press

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;     // accepted level, active-low like key_n
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_valid;     // synchroniser holds real samples once r_valid[1] is set
    logic          r_armed;     // a released key has been seen since reset
    logic          r_press_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_level     <= 1'b1;
            r_cnt       <= '0;
            r_valid     <= 2'b00;
            r_armed     <= 1'b0;
            r_press_evt <= 1'b0;
        end else begin
            r_sync1     <= key_n;
            r_sync2     <= r_sync1;
            r_valid     <= {r_valid[0], 1'b1};
            r_press_evt <= 1'b0;

            // A key held through reset must be released before it may
            // generate a press; the synchroniser reset value does not count
            // as a release, hence the wait on r_valid.
            if (r_valid[1] && r_sync2 && r_level) begin
                r_armed <= 1'b1;
            end

            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level     <= r_sync2;
                r_cnt       <= '0;
                r_press_evt <= r_armed & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressed   = ~r_level;
    assign press_evt = r_press_evt;

endmodule

// File: rtl/key_counter_sequencer.sv
// rtl/key_counter_sequencer.sv - key-driven up/down counter with auto-repeat step
//
// Purpose: debounces four push-buttons, auto-repeats the step key while held,
//          resolves same-cycle commands and applies wrap or saturate stepping
//          to a shared W-bit counter.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   key_n[3:0]  in   raw active-low buttons: [0] step, [1] dir, [2] clear, [3] mode
//   cnt[W-1:0]  out  counter value
//   dir         out  0 = count up, 1 = count down
//   sat_mode    out  0 = wrap, 1 = saturate
//   step_pulse  out  one-cycle strobe on every step applied to cnt
//   limit_hit   out  one-cycle strobe when a step is blocked by saturation
//   pressed[3:0] out debounced key state, 1 = held

module key_counter_sequencer
    import key_counter_pkg::*;
#(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   key_n,
    output logic [W-1:0] cnt,
    output logic         dir,
    output logic         sat_mode,
    output logic         step_pulse,
    output logic         limit_hit,
    output logic [3:0]   pressed
);

    localparam int            TMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            TW       = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
    localparam logic [W-1:0]  CNT_MAX  = '1;

    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] w_press_evt;

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .reset     (reset),
                .key_n     (key_n[g]),
                .pressed   (w_pressed[g]),
                .press_evt (w_press_evt[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Step auto-repeat
    // ------------------------------------------------------------------
    rep_state_t    r_state;
    logic [TW-1:0] r_timer;
    logic          w_held;
    logic          w_timer_zero;
    logic          w_step;

    assign w_held       = w_pressed[KEY_STEP];
    assign w_timer_zero = (r_timer == '0);

    // Step request is decoded from the current state so the counter can
    // act on it in the same edge that advances the FSM; registering it
    // would add a cycle to every step.
    always_comb begin
        w_step = 1'b0;
        case (r_state)
            ST_IDLE:   w_step = w_press_evt[KEY_STEP];
            ST_DELAY:  w_step = w_held && w_timer_zero;
            ST_REPEAT: w_step = w_held && w_timer_zero;
            default:   w_step = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press_evt[KEY_STEP]) begin
                        r_timer <= T_DELAY;
                        r_state <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!w_held) begin
                        r_state <= ST_IDLE;
                    end else if (w_timer_zero) begin
                        r_timer <= T_PERIOD;
                        r_state <= ST_REPEAT;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!w_held) begin
                        r_state <= ST_IDLE;
                    end else if (w_timer_zero) begin
                        r_timer <= T_PERIOD;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command resolution and counter
    // ------------------------------------------------------------------
    logic [W-1:0] r_cnt;
    logic         r_dir;
    logic         r_sat;
    logic         r_step_pulse;
    logic         r_limit_hit;
    logic         w_blocked;

    assign w_blocked = r_sat && (r_dir ? (r_cnt == '0) : (r_cnt == CNT_MAX));

    // All reads of r_dir / r_sat see the pre-toggle values, so a step that
    // coincides with a toggle uses the old direction and mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_sat        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_limit_hit  <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            r_limit_hit  <= 1'b0;

            if (w_press_evt[KEY_DIR]) begin
                r_dir <= ~r_dir;
            end
            if (w_press_evt[KEY_MODE]) begin
                r_sat <= ~r_sat;
            end

            // Clear wins over a same-cycle step, which is dropped silently.
            if (w_press_evt[KEY_CLR]) begin
                r_cnt <= '0;
            end else if (w_step) begin
                if (w_blocked) begin
                    r_limit_hit <= 1'b1;
                end else begin
                    r_cnt        <= r_dir ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
                    r_step_pulse <= 1'b1;
                end
            end
        end
    end

    assign cnt        = r_cnt;
    assign dir        = r_dir;
    assign sat_mode   = r_sat;
    assign step_pulse = r_step_pulse;
    assign limit_hit  = r_limit_hit;
    assign pressed    = w_pressed;

endmodule

// File: tb/tb_key_counter_sequencer.sv
// tb/tb_key_counter_sequencer.sv - self-checking bench for key_counter_sequencer

module tb_key_counter_sequencer;

    localparam int W   = 4;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = 2 + DEB;   // key_n fall to step, checked with +/-1 tolerance

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   key_n = 4'hF;
    logic [W-1:0] cnt;
    logic         dir;
    logic         sat_mode;
    logic         step_pulse;
    logic         limit_hit;
    logic [3:0]   pressed;

    key_counter_sequencer #(
        .W               (W),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .cnt        (cnt),
        .dir        (dir),
        .sat_mode   (sat_mode),
        .step_pulse (step_pulse),
        .limit_hit  (limit_hit),
        .pressed    (pressed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit lim;
        int cntv;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic void expect_evt(bit lim, int cntv, int center);
        exp_t e;
        e.lim  = lim;
        e.cntv = cntv;
        e.lo   = center - 1;
        e.hi   = center + 1;
        sb.push_back(e);
    endfunction

    // Every step_pulse / limit_hit strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && (step_pulse || limit_hit)) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_event cyc=%0d step=%0b lim=%0b cnt=%0d expected no event",
                       cyc, step_pulse, limit_hit, cnt);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                total += 3;
                assert ({step_pulse, limit_hit} === {~mon_e.lim, mon_e.lim}) else begin
                    bad++;
                    $error("FAIL event_kind cyc=%0d observed step=%0b lim=%0b expected lim=%0b",
                           cyc, step_pulse, limit_hit, mon_e.lim);
                end
                assert (cnt === 4'(mon_e.cntv)) else begin
                    bad++;
                    $error("FAIL event_cnt cyc=%0d observed=%0d expected=%0d", cyc, cnt, mon_e.cntv);
                end
                assert (cyc >= mon_e.lo && cyc <= mon_e.hi) else begin
                    bad++;
                    $error("FAIL event_time observed=%0d expected=%0d..%0d", cyc, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the masked keys low for 'hold' cycles, release, then idle 'gap' cycles.
    task automatic press(logic [3:0] mask, int hold, int gap);
        key_n = ~mask;
        tick(hold);
        key_n = 4'hF;
        tick(gap);
    endtask

    int base;
    logic seen;
    int offs [6] = '{0, 20, 28, 36, 44, 52};

    initial begin
        // Reset state
        reset = 1'b1;
        key_n = 4'hF;
        tick(4);
        chk("rst_cnt", cnt, 0);
        chk("rst_dir", dir, 0);
        chk("rst_sat", sat_mode, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_limit", limit_hit, 0);
        chk("rst_pressed", pressed, 0);
        reset = 1'b0;
        tick(10);

        // Glitch of 3 cycles is ignored
        seen = 1'b0;
        key_n[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen |= pressed[0];
        end
        key_n[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            seen |= pressed[0];
        end
        chk("glitch_pressed", seen, 0);
        chk("glitch_cnt", cnt, 0);

        // Single press, one step
        expect_evt(0, 1, cyc + LAT);
        press(4'b0001, 10, 20);
        chk("single_cnt", cnt, 1);

        // Clear, then auto-repeat: six steps while held
        press(4'b0100, 8, 12);
        chk("clear_cnt", cnt, 0);
        base = cyc + LAT;
        for (int k = 0; k < 6; k++) expect_evt(0, k + 1, base + offs[k]);
        press(4'b0001, 56, 30);
        chk("repeat_cnt", cnt, 6);

        // Down with wrap: 0 -> 15
        press(4'b0100, 8, 12);
        press(4'b0010, 8, 12);
        chk("dir_toggle", dir, 1);
        expect_evt(0, 15, cyc + LAT);
        press(4'b0001, 8, 12);
        chk("wrap_down_cnt", cnt, 15);

        // Saturate at 0 going down: limit_hit, cnt holds
        press(4'b1000, 8, 12);
        chk("mode_toggle", sat_mode, 1);
        press(4'b0100, 8, 12);
        chk("clear2_cnt", cnt, 0);
        expect_evt(1, 0, cyc + LAT);
        press(4'b0001, 8, 12);
        chk("sat_cnt", cnt, 0);

        // Count up to 5, then step+clear collide
        press(4'b0010, 8, 12);
        chk("dir_up", dir, 0);
        for (int i = 1; i <= 5; i++) begin
            expect_evt(0, i, cyc + LAT);
            press(4'b0001, 8, 12);
        end
        chk("pre_clr_cnt", cnt, 5);
        press(4'b0101, 8, 12);
        chk("step_clr_cnt", cnt, 0);

        // Count up to 5, then step+dir collide: step uses old dir
        for (int i = 1; i <= 5; i++) begin
            expect_evt(0, i, cyc + LAT);
            press(4'b0001, 8, 12);
        end
        expect_evt(0, 6, cyc + LAT);
        press(4'b0011, 8, 12);
        chk("step_dir_cnt", cnt, 6);
        chk("step_dir_dir", dir, 1);

        // Reset while repeating with the step key still held
        base = cyc + LAT;
        expect_evt(0, 5, base);
        expect_evt(0, 4, base + RD);
        key_n[0] = 1'b0;
        tick(32);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("midrst_cnt", cnt, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_sat", sat_mode, 0);
        tick(30);
        chk("held_after_rst_cnt", cnt, 0);
        key_n[0] = 1'b1;
        tick(15);
        expect_evt(0, 1, cyc + LAT);
        press(4'b0001, 8, 12);
        chk("repress_cnt", cnt, 1);

        tick(5);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL missing_events observed_pending=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
